// File: rtl/hello_cond_pkg.sv
// rtl/hello_cond_pkg.sv - shared constants and helpers for the input conditioner
//
// Purpose: default parameter values and the debounce counter width helper,
//          shared by the conditioner RTL and its testbench.
// Ports:   none (package).
package hello_cond_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_SYNC     = 2;
    localparam int DEF_DEBOUNCE = 4;

    // Bits needed to hold a debounce count of 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hello_cond_if.sv
// rtl/hello_cond_if.sv - signal bundle between raw inputs and conditioned outputs
//
// Purpose: groups the enable, raw inputs and conditioned outputs of the conditioner.
// Ports:   en   - filter enable (driven by master)
//          A    - WIDTH raw asynchronous inputs (driven by master)
//          B    - WIDTH debounced level / toggle state (driven by slave)
//          rise - WIDTH one-cycle debounced rising-edge pulses (driven by slave)
//          fall - WIDTH one-cycle debounced falling-edge pulses (driven by slave)
interface hello_cond_if
    import hello_cond_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (output en, output A, input B, input rise, input fall);
    modport slave  (input en, input A, output B, output rise, output fall);
endinterface

// File: rtl/hello_cond_chan.sv
// rtl/hello_cond_chan.sv - one conditioner channel: synchroniser, debounce filter, edge detector
//
// Purpose: turns one asynchronous input bit into a clean debounced level plus
//          registered rise/fall pulses. Build option HELLO_COND_TOGGLE_EN makes
//          b_o a push-on/push-off toggle advanced by each debounced rising edge.
// Ports:   clk     - clock, all logic on posedge
//          rst     - synchronous active-high reset
//          en_i    - 1 = filter runs, 0 = counter cleared and state held
//          a_i     - raw asynchronous input
//          b_o     - debounced level (or toggle state)
//          rise_o  - one-cycle pulse on debounced 0->1
//          fall_o  - one-cycle pulse on debounced 1->0
module hello_cond_chan
    import hello_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC,
    parameter int   DEBOUNCE    = DEF_DEBOUNCE,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic a_i,
    output logic b_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW      = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], a_i};
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!en_i || (s == state_q)) begin
            // Any sample agreeing with the current state restarts the count.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            state_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_BIT}};
            cnt_q   <= '0;
            state_q <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef HELLO_COND_TOGGLE_EN
    logic tog_q, tog_d;

    // Only debounced presses advance the toggle; releases are ignored.
    always_comb begin
        tog_d = tog_q ^ rise_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tog_q <= RESET_BIT;
        end else begin
            tog_q <= tog_d;
        end
    end

    assign b_o = tog_q;
`else
    assign b_o = state_q;
`endif

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/hello_conditioner.sv
// rtl/hello_conditioner.sv - WIDTH-channel input conditioner top
//
// Purpose: conditions WIDTH asynchronous switch/button inputs into clean
//          synchronous levels plus rise/fall event pulses, one independent
//          hello_cond_chan per bit. Build option HELLO_COND_TOGGLE_EN selects
//          push-on/push-off behaviour for B (handled inside each channel).
// Ports:   clk - clock, all logic on posedge
//          rst - synchronous active-high reset
//          bus - hello_cond_if slave: en, A in; B, rise, fall out
module hello_conditioner
    import hello_cond_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               SYNC_STAGES = DEF_SYNC,
    parameter int               DEBOUNCE    = DEF_DEBOUNCE,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic          clk,
    input  logic          rst,
    hello_cond_if.slave   bus
);

    logic [WIDTH-1:0] b_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        hello_cond_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .RESET_BIT   (RESET_VAL[i])
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .en_i   (bus.en),
            .a_i    (bus.A[i]),
            .b_o    (b_w[i]),
            .rise_o (rise_w[i]),
            .fall_o (fall_w[i])
        );
    end

    assign bus.B    = b_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

endmodule

// File: tb/tb_hello_conditioner.sv
// tb/tb_hello_conditioner.sv - scoreboard testbench for hello_conditioner
module tb_hello_conditioner;
    import hello_cond_pkg::*;

    localparam int               W  = DEF_WIDTH;
    localparam int               S  = DEF_SYNC;
    localparam int               D  = DEF_DEBOUNCE;
    localparam logic [W-1:0]     RV = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hello_cond_if #(.WIDTH(W)) bus ();

    hello_conditioner #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .DEBOUNCE    (D),
        .RESET_VAL   (RV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [W-1:0] b;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: a delay line for the synchroniser, and per channel the
    // number of consecutive enabled edges the synchronised input disagreed
    // with the debounced level.
    logic [W-1:0] pipe_m[$];
    logic [W-1:0] state_m;
    logic [W-1:0] tog_m;
    int           run_m[W];

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    string phase    = "reset";

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s phase=%s cyc=%0d actual=%h required=%h", name, phase, cyc, act, req);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [W-1:0] a);
        exp_t         x;
        logic [W-1:0] s;
        @(negedge clk);
        rst    = r;
        bus.en = e;
        bus.A  = a;
        cyc++;
        x.rise = '0;
        x.fall = '0;
        s = pipe_m[S-1];
        if (r) begin
            pipe_m.delete();
            for (int k = 0; k < S; k++) pipe_m.push_back(RV);
            state_m = RV;
            tog_m   = RV;
            for (int i = 0; i < W; i++) run_m[i] = 0;
        end else begin
            pipe_m.push_front(a);
            void'(pipe_m.pop_back());
            for (int i = 0; i < W; i++) begin
                if (!e || s[i] == state_m[i]) begin
                    run_m[i] = 0;
                end else begin
                    run_m[i]++;
                    if (run_m[i] == D) begin
                        run_m[i]   = 0;
                        state_m[i] = s[i];
                        if (s[i]) begin
                            x.rise[i] = 1'b1;
                            tog_m[i]  = ~tog_m[i];
                        end else begin
                            x.fall[i] = 1'b1;
                        end
                    end
                end
            end
        end
`ifdef HELLO_COND_TOGGLE_EN
        x.b = tog_m;
`else
        x.b = state_m;
`endif
        sb_q.push_back(x);
    endtask

    task automatic hold(input logic e, input logic [W-1:0] a, input int n);
        for (int k = 0; k < n; k++) step(1'b0, e, a);
    endtask

    // Monitor: outputs are valid every cycle; compare just after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk("B", bus.B, x.b);
                chk("rise", bus.rise, x.rise);
                chk("fall", bus.fall, x.fall);
                chk("rise_and_fall", bus.rise & bus.fall, '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog phase=%s cyc=%0d actual=timeout required=finish", phase, cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] v;
        for (int k = 0; k < S; k++) pipe_m.push_back(RV);
        state_m = RV;
        tog_m   = RV;
        bus.en  = 1'b1;
        bus.A   = '1;

        phase = "reset";
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);

        phase = "clean_step";
        hold(1'b1, 8'h01, 8);

        phase = "glitch";
        hold(1'b1, 8'h03, 3);
        hold(1'b1, 8'h01, 8);
        hold(1'b1, 8'h03, 8);

        phase = "multi";
        hold(1'b1, 8'h00, 8);
        hold(1'b1, 8'hA5, 8);
        hold(1'b1, 8'h00, 8);

        phase = "en_mid_count";
        hold(1'b1, 8'h04, 4);
        hold(1'b0, 8'h04, 5);
        hold(1'b1, 8'h04, 8);
        hold(1'b1, 8'h00, 8);

        phase = "rst_mid_count";
        hold(1'b1, 8'h04, 5);
        step(1'b1, 1'b1, 8'h04);
        hold(1'b1, 8'h04, 10);

        phase = "press_twice";
        hold(1'b1, 8'h00, 8);
        hold(1'b1, 8'h01, 8);
        hold(1'b1, 8'h00, 8);
        hold(1'b1, 8'h01, 8);
        hold(1'b1, 8'h00, 8);

        phase = "random";
        for (int n = 0; n < 300; n++) begin
            v = W'($urandom);
            if ($urandom_range(0, 99) < 2) begin
                step(1'b1, 1'b1, v);
            end else begin
                hold($urandom_range(0, 9) != 0, v, int'($urandom_range(1, 9)));
            end
        end

        phase = "drain";
        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
